pulse_sync_arbiter: RTL and testbench
=====================================

// Module: pulse_sync_arbiter
// PURPOSE
//  Shares one single-bit pulse synchronizer (fast->slow domain) among N_CH event sources in the fast domain.
//  Latches one-cycle event pulses per channel and picks a pending channel round-robin.
//  Launches one pulse into the synchronizer and waits on its busy flag.
//  Holds the channel ID stable as a quasi-static sideband and reports completion/overrun per channel.
//  Sits in the fastclk domain between the event sources and the synchronizer.
// PARAMETERS
//  N_CH      4     number of requesting channels (2..16)
//  TIMEOUT   255   max cycles in WAIT_ACK/WAIT_DONE before abort (8-bit counter)
// PORTS
//  clk          in   1       fast-domain clock (the synchronizer's fastclk)
//  rst_n        in   1       asynchronous reset, active-low
//  req_pulse    in   N_CH    one-cycle event per channel
//  sync_busy    in   1       synchronizer busy flag
//  sync_pulse   out  1       one-cycle launch into synchronizer pulse input
//  sync_chan    out  CHAN_W  channel in flight; CHAN_W=$clog2(N_CH); stable LAUNCH..DONE
//  done_vld     out  1       one-cycle: transfer for done_chan completed
//  done_chan    out  CHAN_W  channel just completed
//  pending      out  N_CH    per-channel pending flags
//  overrun      out  N_CH    sticky: event arrived while channel already pending
//  ovr_clr      in   N_CH    write-1-to-clear for overrun bits
//  timeout_err  out  1       sticky: synchronizer handshake timed out; cleared only by reset
//  idle         out  1       state==IDLE and pending==0
// BEHAVIOUR
//  Reset (async on rst_n low):
//   - state=IDLE; pending, overrun, timeout_err, sync_pulse and done_vld = 0.
//   - sync_chan, done_chan = 0; RR pointer = 0; idle=1.
//   - The synchronizer is reset by the same reset. A reset mid-transfer discards the transfer without a done_vld.
//  Pending:
//   - req_pulse[i] sets pending[i] at the next edge.
//   - pending[i] clears on the cycle channel i is granted (IDLE->LAUNCH).
//   - req_pulse[i] on that same grant cycle re-sets pending[i]; this is not an overrun.
//   - req_pulse[i] while pending[i]=1 and i is not being granted sets overrun[i].
//   - ovr_clr[i] and a new overrun on the same cycle: set wins.
//  FSM (registered outputs):
//   - IDLE: if |pending, grant the first pending channel at or after rr_ptr (wrapping modulo N_CH).
//     On grant: load sync_chan, set rr_ptr=grant+1 (wrap to 0 after N_CH-1), go to LAUNCH. Otherwise stay.
//   - LAUNCH: sync_pulse=1 for exactly this cycle; go to WAIT_ACK; clear tmo_cnt.
//   - WAIT_ACK: wait for sync_busy=1, then go to WAIT_DONE.
//     Normal ack arrives 1 cycle after LAUNCH (busy is registered in the synchronizer).
//   - WAIT_DONE: wait for sync_busy=0 (busy stays continuously high through the transfer).
//     Then go to DONE.
//   - DONE: done_vld=1 and done_chan=sync_chan for 1 cycle, then IDLE.
//     The earliest next grant is decided in IDLE, giving 1 idle cycle between transfers.
//  Timeout:
//   - tmo_cnt increments each cycle in WAIT_ACK/WAIT_DONE.
//   - At tmo_cnt==TIMEOUT: set timeout_err, go to IDLE, no done_vld, do not re-queue the channel.
//  sync_chan changes only on grant. Minimum LAUNCH->DONE latency is 3 cycles plus the synchronizer round trip.
//  Fairness: with all channels permanently pending, grants cycle 0,1,..,N_CH-1,0.
//  No single channel is granted twice while another channel is pending.
// STRUCTURE
//  Shared package pulse_sync_pkg:
//   - state encodings (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, DONE), 3-bit.
//   - TIMEOUT counter width constant.
//  Sub-module rr_arbiter:
//   - inputs: req[N_CH], ptr[CHAN_W]; outputs: gnt_vld, gnt_idx.
//   - purely combinational priority search, reusable elsewhere.
//  Top level holds the pending/overrun registers, FSM and timeout counter.
// TESTING
//  Bench: the real synchronizer, fastclk 200 MHz, slowclk 100 MHz.
//  1. After reset, req_pulse=4'b0100 for 1 cycle:
//     -> sync_pulse once, sync_chan=2 stable until done_vld, done_chan=2, idle=1 afterwards.
//  2. req_pulse=4'b1111 together:
//     -> four transfers in order 0,1,2,3; exactly one sync_pulse per done_vld; no overrun.
//  3. Second req_pulse[1] while ch1 is pending and ch0 is in flight:
//     -> overrun[1]=1. ovr_clr[1]=1 -> overrun[1]=0.
//  4. req_pulse[3] on the cycle ch3 is granted:
//     -> pending[3] stays 1, a second ch3 transfer follows, overrun[3]=0.
//  5. sync_busy forced to 0 after LAUNCH:
//     -> timeout_err=1 after TIMEOUT+1 cycles, FSM returns to IDLE, no done_vld; other channels still serviced.
//  6. Assert rst_n=0 in WAIT_DONE:
//     -> all outputs return to their reset values immediately, no spurious done_vld after release.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// ---------------------------------------------------------------------------
// pulse_sync_pkg
//   Shared definitions for the pulse synchronizer arbiter.
//   - state_t : transfer FSM states (3-bit encoding)
//   - TMO_W   : width of the handshake timeout counter
// ---------------------------------------------------------------------------
package pulse_sync_pkg;

  localparam int TMO_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/pulse_sync_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin priority search. Returns the first asserted
//   request at or after ptr, wrapping modulo N_CH.
//   Ports:
//     req     in  N_CH    request vector
//     ptr     in  CHAN_W  highest-priority position (must be < N_CH)
//     gnt_vld out 1       at least one request present
//     gnt_idx out CHAN_W  index of the selected request (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_CH   = 4,
  parameter int CHAN_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]   req,
  input  logic [CHAN_W-1:0] ptr,
  output logic              gnt_vld,
  output logic [CHAN_W-1:0] gnt_idx
);

  always_comb begin
    int unsigned      pos;
    logic [CHAN_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    idx     = '0;
    // Scan from the farthest offset down to ptr so the closest hit is the
    // one left standing.
    for (int k = N_CH - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N_CH) begin
        pos = pos - N_CH;
      end
      idx = CHAN_W'(pos);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/pulse_sync_arbiter.sv
// ---------------------------------------------------------------------------
// pulse_sync_arbiter
//   Shares one fast->slow single-bit pulse synchronizer among N_CH event
//   sources. Event pulses are latched as pending flags, a pending channel is
//   picked round-robin, one pulse is launched and the synchronizer busy flag
//   is followed until the transfer completes (or times out).
//   Ports:
//     clk         in  1       fast-domain clock
//     rst_n       in  1       asynchronous reset, active-low
//     req_pulse   in  N_CH    one-cycle event per channel
//     sync_busy   in  1       synchronizer busy flag
//     sync_pulse  out 1       one-cycle launch into the synchronizer
//     sync_chan   out CHAN_W  channel in flight, changes only on grant
//     done_vld    out 1       one-cycle completion strobe
//     done_chan   out CHAN_W  channel just completed
//     pending     out N_CH    per-channel pending flags
//     overrun     out N_CH    sticky event-while-pending flags
//     ovr_clr     in  N_CH    write-1-to-clear for overrun
//     timeout_err out 1       sticky handshake timeout, cleared by reset only
//     idle        out 1       FSM idle and nothing pending
// ---------------------------------------------------------------------------
module pulse_sync_arbiter
  import pulse_sync_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int TIMEOUT = 255,
  localparam int CHAN_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req_pulse,
  input  logic              sync_busy,
  output logic              sync_pulse,
  output logic [CHAN_W-1:0] sync_chan,
  output logic              done_vld,
  output logic [CHAN_W-1:0] done_chan,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   overrun,
  input  logic [N_CH-1:0]   ovr_clr,
  output logic              timeout_err,
  output logic              idle
);

  state_t            state;
  logic [CHAN_W-1:0] rr_ptr;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              gnt_vld;
  logic [CHAN_W-1:0] gnt_idx;
  logic              grant;
  logic [N_CH-1:0]   gnt_mask;
  logic              tmo_hit;

  rr_arbiter #(
    .N_CH   (N_CH),
    .CHAN_W (CHAN_W)
  ) u_rr_arbiter (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign grant    = (state == IDLE) && gnt_vld;
  assign gnt_mask = grant ? (N_CH'(1) << gnt_idx) : '0;
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT));
  assign idle     = (state == IDLE) && (pending == '0);

  // A new event on the grant cycle re-arms the channel; only an event that
  // lands on a still-pending, not-granted channel counts as an overrun.
  // A fresh overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~gnt_mask) | req_pulse;
      overrun <= (overrun & ~ovr_clr) | (req_pulse & pending & ~gnt_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      sync_pulse  <= 1'b0;
      sync_chan   <= '0;
      done_vld    <= 1'b0;
      done_chan   <= '0;
      timeout_err <= 1'b0;
    end else begin
      sync_pulse <= 1'b0;
      done_vld   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            sync_chan  <= gnt_idx;
            rr_ptr     <= (gnt_idx == CHAN_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
            sync_pulse <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT_ACK;
        end
        // The timeout budget spans both wait states; an abort drops the
        // transfer without a completion strobe.
        WAIT_ACK: begin
          if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (sync_busy) begin
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (!sync_busy) begin
              done_vld  <= 1'b1;
              done_chan <= sync_chan;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pulse_sync_arbiter
//   Bench for pulse_sync_arbiter with a behavioural toggle-based pulse
//   synchronizer (fastclk 200 MHz, slowclk 100 MHz) sharing the reset.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_pulse_sync_arbiter;

  localparam int N_CH    = 4;
  localparam int CHAN_W  = 2;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              slow_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH-1:0]   req_pulse = '0;
  logic [N_CH-1:0]   ovr_clr = '0;
  logic              sync_busy;
  logic              sync_pulse;
  logic [CHAN_W-1:0] sync_chan;
  logic              done_vld;
  logic [CHAN_W-1:0] done_chan;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   overrun;
  logic              timeout_err;
  logic              idle;

  always #2.5 clk = ~clk;
  always #5   slow_clk = ~slow_clk;

  pulse_sync_arbiter #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_pulse   (req_pulse),
    .sync_busy   (sync_busy),
    .sync_pulse  (sync_pulse),
    .sync_chan   (sync_chan),
    .done_vld    (done_vld),
    .done_chan   (done_chan),
    .pending     (pending),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr),
    .timeout_err (timeout_err),
    .idle        (idle)
  );

  // Toggle pulse synchronizer: busy is registered, request toggle crosses to
  // slowclk, is echoed back and busy drops when the echo arrives.
  logic sy_busy, sy_req_tgl, sy_af1, sy_af2, sy_af3;
  logic sy_s1, sy_s2, sy_ack_tgl;
  logic busy_kill = 1'b0;

  assign sync_busy = sy_busy & ~busy_kill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy_busy <= 1'b0; sy_req_tgl <= 1'b0;
      sy_af1 <= 1'b0; sy_af2 <= 1'b0; sy_af3 <= 1'b0;
    end else begin
      sy_af1 <= sy_ack_tgl; sy_af2 <= sy_af1; sy_af3 <= sy_af2;
      if (sync_pulse && !sy_busy) begin
        sy_req_tgl <= ~sy_req_tgl;
        sy_busy    <= 1'b1;
      end else if (sy_af2 != sy_af3) begin
        sy_busy <= 1'b0;
      end
    end
  end

  always @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      sy_s1 <= 1'b0; sy_s2 <= 1'b0; sy_ack_tgl <= 1'b0;
    end else begin
      sy_s1 <= sy_req_tgl; sy_s2 <= sy_s1; sy_ack_tgl <= sy_s2;
    end
  end

  // Launch counter and in-flight channel stability monitor.
  int         launches = 0;
  int         mon_err = 0;
  logic [1:0] launch_chan = '0;
  bit         in_flight = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
    end else begin
      mon_err <= mon_err
               + ((in_flight && !sync_pulse && sync_chan != launch_chan) ? 1 : 0)
               + ((done_vld && (!in_flight || done_chan != launch_chan)) ? 1 : 0);
      if (sync_pulse) begin
        launches    <= launches + 1;
        launch_chan <= sync_chan;
        in_flight   <= 1'b1;
      end else if (done_vld) begin
        in_flight <= 1'b0;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_pulse = '0; ovr_clr = '0; busy_kill = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] out_vec();
    return {sync_pulse, done_vld, timeout_err, pending, overrun, sync_chan, done_chan, idle};
  endfunction

  // Wait for the next done_vld within a cycle bound; returns 0 on expiry.
  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge clk);
      if (done_vld) seen = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0]      req;
    int              n;
    logic [3:0][1:0] chans;
    logic [3:0]      ovr;
  } vec_t;

  vec_t vecs[5];

  task automatic run_table();
    int  got, cyc, extra, l0;
    vecs[0] = '{4'b0100, 1, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000};
    vecs[1] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000};
    vecs[2] = '{4'b1010, 2, {2'd0, 2'd0, 2'd3, 2'd1}, 4'b0000};
    vecs[3] = '{4'b1001, 2, {2'd0, 2'd0, 2'd3, 2'd0}, 4'b0000};
    vecs[4] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      check($sformatf("vec%0d_reset_outputs", i), 32'(out_vec()), 32'h0001);
      l0 = launches;
      req_pulse = vecs[i].req;
      @(negedge clk);
      req_pulse = '0;
      got = 0; cyc = 0;
      while (got < vecs[i].n && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (done_vld) begin
          check($sformatf("vec%0d_done_chan%0d", i, got), 32'(done_chan), 32'(vecs[i].chans[got]));
          got++;
        end
      end
      check($sformatf("vec%0d_done_count", i), got, vecs[i].n);
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done_vld) extra++;
      end
      check($sformatf("vec%0d_extra_done", i), extra, 0);
      check($sformatf("vec%0d_idle_after", i), 32'(idle), 32'd1);
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].ovr));
      check($sformatf("vec%0d_launches", i), launches - l0, vecs[i].n);
      $display("vector %0d: req=%b dones=%0d launches=%0d", i, vecs[i].req, got, launches - l0);
    end
  endtask

  task automatic seq_overrun();
    bit seen;
    do_reset();
    req_pulse = 4'b0011; @(negedge clk); req_pulse = '0;
    @(negedge clk);                      // ch0 granted on this edge
    check("ovr_grant_ch0", {sync_pulse, sync_chan, pending}, {1'b1, 2'd0, 4'b0010});
    req_pulse = 4'b0010; @(negedge clk); req_pulse = '0;
    check("ovr_set_ch1", 32'(overrun), 32'b0010);
    ovr_clr = 4'b0010; @(negedge clk); ovr_clr = '0;
    check("ovr_clear_ch1", 32'(overrun), 32'b0000);
    req_pulse = 4'b0010; ovr_clr = 4'b0010; @(negedge clk);
    req_pulse = '0; ovr_clr = '0;
    check("ovr_set_beats_clear", 32'(overrun), 32'b0010);
    ovr_clr = 4'b0010; @(negedge clk); ovr_clr = '0;
    wait_done(100, seen);
    check("ovr_first_done_ch0", {seen, done_chan}, {1'b1, 2'd0});
    wait_done(100, seen);
    check("ovr_second_done_ch1", {seen, done_chan}, {1'b1, 2'd1});
    $display("sequence overrun: overrun=%b", overrun);
  endtask

  task automatic seq_regrant();
    bit seen;
    int l0;
    do_reset();
    l0 = launches;
    req_pulse = 4'b1000; @(negedge clk);
    @(negedge clk);                      // grant edge with req_pulse[3] still high
    req_pulse = '0;
    check("regrant_launch", {sync_pulse, sync_chan, pending, overrun}, {1'b1, 2'd3, 4'b1000, 4'b0000});
    wait_done(100, seen);
    check("regrant_done1", {seen, done_chan}, {1'b1, 2'd3});
    wait_done(100, seen);
    check("regrant_done2", {seen, done_chan}, {1'b1, 2'd3});
    repeat (10) @(negedge clk);
    check("regrant_overrun", 32'(overrun), 32'd0);
    check("regrant_launches", launches - l0, 2);
    $display("sequence regrant: launches=%0d", launches - l0);
  endtask

  task automatic seq_timeout();
    int  cyc, dcount;
    bit  seen;
    do_reset();
    busy_kill = 1'b1;
    req_pulse = 4'b0101; @(negedge clk); req_pulse = '0;
    @(negedge clk);
    check("tmo_launch_ch0", {sync_pulse, sync_chan}, {1'b1, 2'd0});
    cyc = 0; dcount = 0;
    while (!timeout_err && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done_vld) dcount++;
    end
    // One LAUNCH cycle plus TIMEOUT+1 cycles of waiting.
    check("tmo_latency", cyc, TIMEOUT + 2);
    check("tmo_no_done", dcount, 0);
    check("tmo_pending_ch2", 32'(pending), 32'b0100);
    busy_kill = 1'b0;
    wait_done(100, seen);
    check("tmo_next_served_ch2", {seen, done_chan}, {1'b1, 2'd2});
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    $display("sequence timeout: cycles=%0d", cyc);
  endtask

  task automatic seq_reset_mid();
    int c, dcount, l0;
    do_reset();
    req_pulse = 4'b0001; @(negedge clk); req_pulse = '0;
    c = 0;
    while (!sync_busy && c < 50) begin @(negedge clk); c++; end
    check("rst_saw_busy", 32'(sync_busy), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outputs", 32'(out_vec()), 32'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    l0 = launches; dcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_vld) dcount++;
    end
    check("rst_no_spurious_done", dcount, 0);
    check("rst_no_relaunch", launches - l0, 0);
    check("rst_idle", 32'(idle), 32'd1);
    $display("sequence reset mid-transfer: dones=%0d", dcount);
  endtask

  // Reference model: pending/overrun as set arithmetic, round-robin as a
  // wrap-around search, FSM reduced to "ready to grant" vs "transfer busy".
  task automatic rand_test();
    logic [3:0] mp, mo, r, c, mp_n, mo_n, gmask;
    logic [1:0] mptr, g, m_chan;
    bit         m_idle, m_idle_n, prev_done, grant;
    int         ndone;
    do_reset();
    mp = '0; mo = '0; mptr = '0; m_chan = '0; m_idle = 1'b1; prev_done = 1'b0; ndone = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < N_CH; b++) begin
        r[b] = ($urandom_range(7) == 0);
        c[b] = ($urandom_range(15) == 0);
      end
      req_pulse = r; ovr_clr = c;
      @(negedge clk);
      grant = m_idle && (mp != '0);
      g = mptr; gmask = '0;
      if (grant) begin
        while (!mp[g]) g = g + 2'd1;
        gmask = 4'b0001 << g;
      end
      mp_n     = (mp & ~gmask) | r;
      mo_n     = (mo & ~c) | (r & mp & ~gmask);
      m_idle_n = (m_idle && !grant) || prev_done;
      check("rand_state", {sync_pulse, pending, overrun, idle},
            {grant, mp_n, mo_n, m_idle_n && (mp_n == '0)});
      if (grant) begin
        check("rand_grant_chan", 32'(sync_chan), 32'(g));
        m_chan = g;
        mptr   = g + 2'd1;
      end
      if (done_vld) begin
        ndone++;
        check("rand_done_legal", 32'(!m_idle && !grant), 32'd1);
        check("rand_done_chan", 32'(done_chan), 32'(m_chan));
      end
      prev_done = done_vld;
      mp = mp_n; mo = mo_n; m_idle = m_idle_n;
    end
    req_pulse = '0; ovr_clr = '0;
    $display("random test: 3000 cycles, %0d transfers", ndone);
  endtask

  initial begin
    run_table();
    seq_overrun();
    seq_regrant();
    seq_timeout();
    seq_reset_mid();
    rand_test();
    check("monitor_chan_stable", mon_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
